// File: rtl/gba_sound_dma_sched.sv
// Sound-FIFO DMA scheduler: round-robin refill of FIFO A/B with 4-word read/write bursts.
// Deferred pointer reloads keep the active channel's pointer coherent during a burst.
module gba_sound_dma_sched #(
  parameter logic [31:0] FIFO_A_ADR = 32'h040000A0,
  parameter logic [31:0] FIFO_B_ADR = 32'h040000A4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dma_req_a,
  input  logic        dma_req_b,
  input  logic        en_a,
  input  logic        en_b,
  input  logic        load_a,
  input  logic        load_b,
  input  logic [27:0] src_a,
  input  logic [27:0] src_b,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        active_b
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e      state_q, state_d;
  logic        pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [27:0] ptr_a_q, ptr_a_d, ptr_b_q, ptr_b_d;
  logic [31:0] data_q, data_d;
  logic        last_b_q, last_b_d;
  logic        active_b_q, active_b_d;
  logic        dload_a_q, dload_a_d, dload_b_q, dload_b_d;
  logic [27:0] dval_a_q, dval_a_d, dval_b_q, dval_b_d;
  logic        mem_req_q, mem_req_d, mem_wr_q, mem_wr_d;
  logic [31:0] mem_adr_q, mem_adr_d;

  logic act_a, act_b, act_en, eff_a, eff_b, grant_a, grant_b, burst_end;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_a_d    = ptr_a_q;
    ptr_b_d    = ptr_b_q;
    data_d     = data_q;
    last_b_d   = last_b_q;
    active_b_d = active_b_q;
    dload_a_d  = dload_a_q;
    dload_b_d  = dload_b_q;
    dval_a_d   = dval_a_q;
    dval_b_d   = dval_b_q;
    grant_a    = 1'b0;
    grant_b    = 1'b0;

    act_a  = (state_q != StIdle) && !active_b_q;
    act_b  = (state_q != StIdle) && active_b_q;
    act_en = active_b_q ? en_b : en_a;
    eff_a  = pend_a_q & en_a;
    eff_b  = pend_b_q & en_b;

    // A load aimed at the channel mid-burst is parked until the burst ends.
    if (load_a) begin
      if (act_a) begin
        dload_a_d = 1'b1;
        dval_a_d  = src_a;
      end else begin
        ptr_a_d = src_a;
      end
    end
    if (load_b) begin
      if (act_b) begin
        dload_b_d = 1'b1;
        dval_b_d  = src_b;
      end else begin
        ptr_b_d = src_b;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (eff_a || eff_b) begin
          grant_b    = (eff_a && eff_b) ? !last_b_q : eff_b;
          grant_a    = !grant_b;
          last_b_d   = grant_b;
          active_b_d = grant_b;
          cnt_d      = 2'd0;
          state_d    = StRd;
        end
      end
      StRd: begin
        if (mem_ack) begin
          data_d = mem_rdata;
          if (active_b_q) ptr_b_d = ptr_b_q + 28'd4;
          else            ptr_a_d = ptr_a_q + 28'd4;
          state_d = act_en ? StWr : StIdle;
        end
      end
      StWr: begin
        if (mem_ack) begin
          cnt_d   = cnt_q + 2'd1;
          state_d = (cnt_q == 2'd3 || !act_en) ? StIdle : StRd;
        end
      end
      default: state_d = StIdle;
    endcase

    burst_end = (state_q != StIdle) && (state_d == StIdle);
    if (burst_end) begin
      if (dload_a_d) ptr_a_d = dval_a_d;
      if (dload_b_d) ptr_b_d = dval_b_d;
      dload_a_d = 1'b0;
      dload_b_d = 1'b0;
    end

    pend_a_d = en_a & ((pend_a_q & ~grant_a) | dma_req_a);
    pend_b_d = en_b & ((pend_b_q & ~grant_b) | dma_req_b);

    mem_req_d = (state_d != StIdle);
    mem_wr_d  = (state_d == StWr);
    mem_adr_d = mem_adr_q;
    if (state_d == StRd) begin
      mem_adr_d = {4'h0, active_b_d ? ptr_b_d : ptr_a_d};
    end else if (state_d == StWr) begin
      mem_adr_d = active_b_d ? FIFO_B_ADR : FIFO_A_ADR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
      cnt_q      <= 2'd0;
      ptr_a_q    <= 28'd0;
      ptr_b_q    <= 28'd0;
      data_q     <= 32'd0;
      last_b_q   <= 1'b1;
      active_b_q <= 1'b0;
      dload_a_q  <= 1'b0;
      dload_b_q  <= 1'b0;
      dval_a_q   <= 28'd0;
      dval_b_q   <= 28'd0;
      mem_req_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_adr_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      cnt_q      <= cnt_d;
      ptr_a_q    <= ptr_a_d;
      ptr_b_q    <= ptr_b_d;
      data_q     <= data_d;
      last_b_q   <= last_b_d;
      active_b_q <= active_b_d;
      dload_a_q  <= dload_a_d;
      dload_b_q  <= dload_b_d;
      dval_a_q   <= dval_a_d;
      dval_b_q   <= dval_b_d;
      mem_req_q  <= mem_req_d;
      mem_wr_q   <= mem_wr_d;
      mem_adr_q  <= mem_adr_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_adr   = mem_adr_q;
  assign mem_wdata = data_q;
  assign busy      = (state_q != StIdle);
  assign active_b  = active_b_q;

endmodule

// File: tb/tb_gba_sound_dma_sched.sv
// Bench for gba_sound_dma_sched: directed scenarios plus random traffic against a
// transaction-level model (a burst is a numbered sequence of 8 bus transfers).
module tb_gba_sound_dma_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dma_req_a, dma_req_b, en_a, en_b, load_a, load_b;
  logic [27:0] src_a, src_b;
  logic        mem_req, mem_wr, mem_ack, busy, active_b;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  gba_sound_dma_sched dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .dma_req_a (dma_req_a),
    .dma_req_b (dma_req_b),
    .en_a      (en_a),
    .en_b      (en_b),
    .load_a    (load_a),
    .load_b    (load_b),
    .src_a     (src_a),
    .src_b     (src_b),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .active_b  (active_b)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: burst in flight is m_busy with transfer index m_k (even = read, odd = write).
  bit          m_busy, m_pend[2], m_dpend[2];
  int          m_ch, m_k, m_last;
  logic [27:0] m_ptr[2], m_dval[2];
  logic [31:0] m_data;

  function automatic logic [31:0] fifo_of(input int c);
    return (c == 0) ? 32'h040000A0 : 32'h040000A4;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ch = 0; m_k = 0; m_last = 1; m_data = '0;
    for (int x = 0; x < 2; x++) begin
      m_pend[x] = 0; m_dpend[x] = 0; m_ptr[x] = '0; m_dval[x] = '0;
    end
  endtask

  task automatic model_step();
    bit          en[2], req[2], ld[2], gnt[2];
    logic [27:0] src[2];
    bit          was_busy, ended, e0, e1;
    int          cur;
    en[0] = en_a; en[1] = en_b; req[0] = dma_req_a; req[1] = dma_req_b;
    ld[0] = load_a; ld[1] = load_b; src[0] = src_a; src[1] = src_b;
    gnt[0] = 0; gnt[1] = 0;
    was_busy = m_busy; cur = m_ch; ended = 0;
    if (m_busy && mem_ack) begin
      if (m_k % 2 == 0) begin
        m_data = mem_rdata;
        m_ptr[cur] = m_ptr[cur] + 28'd4;
      end
      m_k++;
      if (m_k == 8 || !en[cur]) begin
        m_busy = 0;
        ended = 1;
      end
    end
    for (int x = 0; x < 2; x++) begin
      if (ld[x]) begin
        if (was_busy && cur == x) begin
          m_dpend[x] = 1;
          m_dval[x] = src[x];
        end else begin
          m_ptr[x] = src[x];
        end
      end
    end
    if (ended && m_dpend[cur]) begin
      m_ptr[cur] = m_dval[cur];
      m_dpend[cur] = 0;
    end
    if (!was_busy) begin
      e0 = m_pend[0] && en[0];
      e1 = m_pend[1] && en[1];
      if (e0 || e1) begin
        m_ch = (e0 && e1) ? 1 - m_last : (e0 ? 0 : 1);
        m_last = m_ch; m_busy = 1; m_k = 0; gnt[m_ch] = 1;
      end
    end
    for (int x = 0; x < 2; x++) m_pend[x] = en[x] && ((m_pend[x] && !gnt[x]) || req[x]);
  endtask

  task automatic check_outputs();
    check_val("busy", 32'(busy), 32'(m_busy));
    check_val("mem_req", 32'(mem_req), 32'(m_busy));
    check_val("active_b", 32'(active_b), 32'(m_ch));
    if (m_busy) begin
      check_val("mem_wr", 32'(mem_wr), 32'(m_k % 2));
      if (m_k % 2 == 0) begin
        check_val("rd_adr", mem_adr, {4'h0, m_ptr[m_ch]});
      end else begin
        check_val("wr_adr", mem_adr, fifo_of(m_ch));
        check_val("wdata", mem_wdata, m_data);
      end
    end else begin
      check_val("mem_wr_idle", 32'(mem_wr), 32'd0);
    end
  endtask

  // Clears pulses; acks only outstanding requests unless stray acks are allowed.
  task automatic drive(input bit always_ack, input bit stray);
    dma_req_a = 0; dma_req_b = 0; load_a = 0; load_b = 0;
    mem_rdata = $urandom;
    if (m_busy) mem_ack = always_ack ? 1'b1 : 1'($urandom_range(0, 1));
    else        mem_ack = stray ? ($urandom_range(0, 7) == 0) : 1'b0;
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      drive(1'b0, 1'b0);
      run_cycle();
      if (!m_busy && !m_pend[0] && !m_pend[1]) break;
    end
    check_val("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic wait_phase(input int k, input int max_cycles);
    for (int i = 0; i < max_cycles && !(m_busy && m_k == k); i++) begin
      drive(1'b1, 1'b0);
      run_cycle();
    end
    check_val("phase_reach", 32'(m_busy && m_k == k), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_reset();
    #12;
    @(negedge clk);
    reset_n = 1;
    check_outputs();
    check_val("rst_adr", mem_adr, 32'd0);
    check_val("rst_wdata", mem_wdata, 32'd0);
  endtask

  initial begin
    dma_req_a = 0; dma_req_b = 0; en_a = 0; en_b = 0; load_a = 0; load_b = 0;
    src_a = '0; src_b = '0; mem_ack = 0; mem_rdata = '0;
    do_reset();

    // Basic A burst from 0x2000000 with immediate acks.
    en_a = 1; en_b = 1;
    drive(1'b1, 1'b0); load_a = 1; src_a = 28'h2000000; run_cycle();
    drive(1'b1, 1'b0); dma_req_a = 1; run_cycle();
    drain(60);
    drive(1'b1, 1'b0); dma_req_a = 1; run_cycle();
    drive(1'b1, 1'b0); run_cycle();
    check_val("ptr_a_end", mem_adr, 32'h02000010);
    drain(60);

    // Simultaneous requests after reset: A first, then B, then A again.
    do_reset();
    en_a = 1; en_b = 1;
    drive(1'b1, 1'b0); dma_req_a = 1; dma_req_b = 1; run_cycle();
    drive(1'b1, 1'b0); run_cycle();
    check_val("tie1_owner", 32'(active_b), 32'd0);
    drain(80);
    drive(1'b1, 1'b0); dma_req_a = 1; dma_req_b = 1; run_cycle();
    drive(1'b1, 1'b0); run_cycle();
    check_val("tie2_owner", 32'(active_b), 32'd0);
    drain(80);

    // Three requests during an A burst collapse into one extra burst.
    drive(1'b0, 1'b0); dma_req_a = 1; run_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0); dma_req_a = 1; run_cycle();
    end
    drain(120);

    // Channel disabled during the second read.
    drive(1'b1, 1'b0); load_a = 1; src_a = 28'h0000100; run_cycle();
    drive(1'b1, 1'b0); dma_req_a = 1; run_cycle();
    wait_phase(2, 20);
    en_a = 0;
    drain(40);
    en_a = 1;
    drive(1'b1, 1'b0); dma_req_a = 1; run_cycle();
    drive(1'b1, 1'b0); run_cycle();
    check_val("abort_ptr", mem_adr, 32'h00000108);
    drain(60);

    // Pointer wrap at the top of the 28-bit space.
    drive(1'b1, 1'b0); load_a = 1; src_a = 28'hFFFFFF8; run_cycle();
    drive(1'b1, 1'b0); dma_req_a = 1; run_cycle();
    wait_phase(4, 20);
    check_val("wrap_adr", mem_adr, 32'h00000000);
    drain(60);

    // Reset during a write: request drops at once, stray acks are ignored.
    drive(1'b0, 1'b0); dma_req_b = 1; run_cycle();
    wait_phase(3, 20);
    mem_ack = 0;
    #2 reset_n = 0;
    #1;
    check_val("rst_mid_req", 32'(mem_req), 32'd0);
    check_val("rst_mid_busy", 32'(busy), 32'd0);
    model_reset();
    mem_ack = 1;
    @(negedge clk);
    reset_n = 1;
    check_outputs();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0); mem_ack = 1; run_cycle();
    end

    // Random traffic.
    en_a = 1; en_b = 1;
    for (int i = 0; i < 4000; i++) begin
      drive(1'b0, 1'b1);
      if ($urandom_range(0, 49) == 0) en_a = ~en_a;
      if ($urandom_range(0, 49) == 0) en_b = ~en_b;
      dma_req_a = ($urandom_range(0, 4) == 0);
      dma_req_b = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 29) == 0) begin
        load_a = 1; src_a = {26'($urandom), 2'b00};
      end
      if ($urandom_range(0, 29) == 0) begin
        load_b = 1; src_b = {26'($urandom), 2'b00};
      end
      run_cycle();
    end
    en_a = 1; en_b = 1;
    drain(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gba_sound_dma_sched.md
GBA_SOUND_DMA_SCHED -- requirements
Module: gba_sound_dma_sched

Interface
REQ-001 Parameter FIFO_A_ADR, default 32'h040000A0, meaning destination address of sound FIFO A.
REQ-002 Parameter FIFO_B_ADR, default 32'h040000A4, meaning destination address of sound FIFO B.
REQ-003 clk  in  1  single system clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 dma_req_a / dma_req_b  in  1 each  single-cycle refill pulses from FIFO A/B sound blocks.
REQ-006 en_a / en_b  in  1 each  channel enable (DMA channel 1/2 sound mode enabled).
REQ-007 load_a / load_b  in  1 each  pulse; latch src_a/src_b into the channel source pointer.
REQ-008 src_a / src_b  in  28 each  word-aligned source start address.
REQ-009 mem_req  out  1  bus request, held until mem_ack.
REQ-010 mem_wr  out  1  1 = write, 0 = read; stable while mem_req high.
REQ-011 mem_adr  out  32  bus address; stable while mem_req high.
REQ-012 mem_wdata  out  32  write data; stable while mem_req high.
REQ-013 mem_rdata  in  32  read data, valid in the mem_ack cycle of a read.
REQ-014 mem_ack  in  1  single-cycle transaction completion.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 active_b  out  1  0 = channel A owns the current burst, 1 = channel B.

Function
REQ-017 Each channel SHALL hold a pending flag, set by dma_req_x when en_x=1; dma_req_x while pending is already set SHALL be absorbed (no queueing depth beyond 1).
REQ-018 Clearing en_x SHALL clear pending_x in the same cycle.
REQ-019 States SHALL be IDLE, RD, WR; a burst SHALL consist of exactly 4 RD->WR word pairs.
REQ-020 In IDLE, if any pending flag is set, the block SHALL select a channel, clear its pending flag, reset word count to 0 and enter RD on the next edge.
REQ-021 Arbitration SHALL be round-robin: if both pending, grant the channel not granted last; last_grant resets to B so A wins the first tie.
REQ-022 RD: mem_req=1, mem_wr=0, mem_adr={4'h0, ptr_x}; on mem_ack latch mem_rdata into the data register, advance ptr_x by 4 (28-bit wrap-around, 28'hFFFFFFC+4 = 0), enter WR.
REQ-023 WR: mem_req=1, mem_wr=1, mem_adr=FIFO_x_ADR, mem_wdata=latched data; on mem_ack increment word count; if count was 3 enter IDLE, else RD.
REQ-024 mem_req SHALL be asserted from the first cycle of RD/WR and deasserted in the cycle after mem_ack; minimum 1 idle cycle between bursts (IDLE visited).
REQ-025 A dma_req for the active channel arriving during its burst SHALL set pending (causes a further burst).
REQ-026 en_x cleared mid-burst for the active channel: the outstanding transaction SHALL complete, then the block SHALL enter IDLE without further words; ptr_x retains its advanced value.
REQ-027 load_x SHALL update ptr_x immediately when channel x is not active; when active, the load SHALL be deferred and applied on the burst's return to IDLE.
REQ-028 Simultaneous load_x and pointer increment for a non-active channel are impossible; for the active channel the deferred load wins over the final increment.
REQ-029 busy SHALL equal (state != IDLE); active_b SHALL hold the last granted channel.

Reset
REQ-030 On reset_n=0, asynchronously: state=IDLE, pending flags=0, word count=0, ptr_a=ptr_b=0, data register=0, last_grant=B, deferred loads cleared.
REQ-031 Reset values: mem_req=0, mem_wr=0, mem_adr=0, mem_wdata=0, busy=0, active_b=0.
REQ-032 Reset asserted mid-transaction SHALL drop mem_req immediately; a mem_ack arriving during or after reset with no request SHALL be ignored.

Verification
REQ-033 load_a with src_a=28'h2000000, en_a=1, dma_req_a pulse, ack 1 cycle later each -> reads 0x02000000,04,08,0C each followed by write to 0x040000A0 with matching data; ptr_a ends 0x2000010; busy low after 8 acks.
REQ-034 dma_req_a and dma_req_b same cycle after reset -> A burst (4 words to 0x040000A0) then B burst (4 words to 0x040000A4); next simultaneous pair -> A first again (last was B).
REQ-035 dma_req_a pulsed 3 times during an A burst -> exactly one extra A burst follows.
REQ-036 en_a dropped during 2nd RD of a burst -> that RD and its WR... not issued: RD completes, no WR, state IDLE, ptr_a advanced by 8.
REQ-037 src_a=28'hFFFFFF8, burst -> read addresses 0x0FFFFFF8, 0x0FFFFFFC, 0x00000000, 0x00000004.
REQ-038 reset_n low in WR with mem_req high -> mem_req=0 same cycle, all state cleared, stray mem_ack afterwards causes no transaction.
